div_unit_64: RTL and testbench

Iterative 64-bit integer divider for the RV64 M-extension execute stage: computes DIV/DIVU/REM/REMU results one quotient bit per cycle by restoring trial subtraction. It is the subtraction-side counterpart of the combinational 64-bit adder. It sits beside the ALU in EX, stalling the pipeline while busy and returning one registered result per accepted request.

---
 rtl/div_unit_64.sv | 158 +++++++++++++++
 tb/tb_div_unit_64.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/div_unit_64.sv
// ---------------------------------------------------------------------------
// div_unit_64
// Iterative restoring divider for RV64 DIV/DIVU/REM/REMU. One quotient bit is
// produced per cycle. Operands are converted to magnitudes on accept, and the
// signs are fixed up in a single FIX cycle. Divide-by-zero and signed overflow
// are resolved at accept and go straight to DONE.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid (held by upstream until accepted)
//   in_ready   unit idle and able to accept
//   dividend   rs1 operand
//   divisor    rs2 operand
//   is_signed  1 = DIV/REM, 0 = DIVU/REMU
//   want_rem   1 = return remainder, 0 = return quotient
//   flush      kill the in-flight operation (no out_valid)
//   out_valid  one-cycle pulse, result valid
//   result     registered quotient or remainder
//   busy       unit not idle (EX stall)
// ---------------------------------------------------------------------------
module div_unit_64 #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            want_rem,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [6:0]        count_q, count_d;
  // Partial remainder is kept at XLEN bits: it is always below the divisor,
  // so its top (65th) bit is never set between iterations.
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              want_rem_q, want_rem_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;

  logic [XLEN:0]     r_shift;
  logic [XLEN:0]     diff;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, sgn_ovf;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return '0 - v;
  endfunction

  assign a_neg    = is_signed & dividend[XLEN-1];
  assign b_neg    = is_signed & divisor[XLEN-1];
  assign abs_a    = a_neg ? negate(dividend) : dividend;
  assign abs_b    = b_neg ? negate(divisor) : divisor;
  assign div_zero = (divisor == '0);
  assign sgn_ovf  = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (divisor == '1);

  // Trial subtraction: diff = R' - D; bit XLEN set means R' < D (restore).
  assign r_shift = {rem_q, quo_q[XLEN-1]};
  assign diff    = r_shift + {1'b1, ~dvs_q} + {{XLEN{1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    result_d   = result_q;
    want_rem_d = want_rem_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          want_rem_d = want_rem;
          neg_q_d    = a_neg ^ b_neg;
          neg_r_d    = a_neg;
          if (div_zero) begin
            result_d = want_rem ? dividend : '1;
            state_d  = DONE;
          end else if (sgn_ovf) begin
            result_d = want_rem ? '0 : dividend;
            state_d  = DONE;
          end else begin
            quo_d   = abs_a;
            dvs_d   = abs_b;
            rem_d   = '0;
            count_d = 7'd64;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_d   = diff[XLEN] ? r_shift[XLEN-1:0] : diff[XLEN-1:0];
        count_d = count_q - 7'd1;
        if (count_q == 7'd1) state_d = FIX;
      end
      FIX: begin
        result_d = want_rem_q ? (neg_r_q ? negate(rem_q) : rem_q)
                              : (neg_q_q ? negate(quo_q) : quo_q);
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush abandons the operation and leaves the last result in place.
    if (flush && (state_q != IDLE)) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      result_q   <= '0;
      want_rem_q <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      result_q   <= result_d;
      want_rem_q <= want_rem_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit_64.sv
module tb_div_unit_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        is_signed;
  logic        want_rem;
  logic        flush;
  logic        out_valid;
  logic [63:0] result;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] last_res = 64'd0;

  always #5 clk = ~clk;

  div_unit_64 #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .want_rem(want_rem), .flush(flush), .out_valid(out_valid),
    .result(result), .busy(busy)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        r;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // Present a request on a falling edge; it is accepted on the next rising edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic r);
    wait_ready();
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; want_rem = r; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic r, input logic [63:0] exp, input int lat);
    int k = 0;
    start_op(a, b, s, r);
    chk({name, "_busy"}, 64'(busy), 64'd1);
    while (!out_valid && k < 200) begin
      @(posedge clk); #1; k++;
    end
    chk({name, "_lat"}, 64'(k), 64'(lat));
    chk({name, "_res"}, result, exp);
    @(posedge clk); #1;
    chk({name, "_pulse"}, 64'(out_valid), 64'd0);
    chk({name, "_idle"}, 64'(in_ready), 64'd1);
    last_res = exp;
  endtask

  initial begin
    vecs[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 65};
    vecs[1]  = '{64'd100, 64'd7, 1'b0, 1'b1, 64'd2, 65};
    vecs[2]  = '{-64'sd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{-64'sd7, 64'd2, 1'b1, 1'b1, ONES, 65};
    vecs[4]  = '{64'd7, -64'sd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[5]  = '{64'd7, -64'sd2, 1'b1, 1'b1, 64'd1, 65};
    vecs[6]  = '{ONES, 64'd1, 1'b0, 1'b0, ONES, 65};
    vecs[7]  = '{64'h1234, 64'd0, 1'b1, 1'b0, ONES, 0};
    vecs[8]  = '{64'h1234, 64'd0, 1'b1, 1'b1, 64'h1234, 0};
    vecs[9]  = '{64'h1234, 64'd0, 1'b0, 1'b0, ONES, 0};
    vecs[10] = '{64'h1234, 64'd0, 1'b0, 1'b1, 64'h1234, 0};
    vecs[11] = '{MINV, ONES, 1'b1, 1'b0, MINV, 0};
    vecs[12] = '{MINV, ONES, 1'b1, 1'b1, 64'd0, 0};
    vecs[13] = '{MINV, ONES, 1'b0, 1'b0, 64'd0, 65};
    vecs[14] = '{MINV, ONES, 1'b0, 1'b1, MINV, 65};
    vecs[15] = '{-64'sd100, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    vecs[16] = '{-64'sd100, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 65};

    in_valid = 1'b0; flush = 1'b0; dividend = '0; divisor = '0;
    is_signed = 1'b0; want_rem = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r,
             vecs[i].exp, vecs[i].lat);

    // flush together with in_valid in IDLE: request must not be taken
    @(negedge clk);
    dividend = 64'd9; divisor = 64'd0; is_signed = 1'b0; want_rem = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_noacc", 64'(busy), 64'd0);

    // flush mid-CALC, with a stray in_valid pulse while busy
    start_op(64'd100, 64'd7, 1'b0, 1'b0);
    for (int c = 1; c < 30; c++) begin
      if (c == 10) begin
        @(negedge clk);
        dividend = 64'h55; divisor = 64'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("busy_ignore_inval", 64'(busy), 64'd1);
    chk("noout_ignore_inval", 64'(out_valid), 64'd0);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_result_kept", result, last_res);
    begin
      int seen = 0;
      for (int c = 0; c < 80; c++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("flush_no_out_valid", 64'(seen), 64'd0);
    end
    run_op("after_flush", 64'd100, 64'd7, 1'b0, 1'b1, 64'd2, 65);

    // asynchronous reset in the middle of CALC
    start_op(64'd1000, 64'd7, 1'b0, 1'b0);
    for (int c = 1; c < 40; c++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", result, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("after_reset", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 65);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
